serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder: one operand bit pair per clock, LSB first.
- Sits directly upstream of the existing full_adder cell and drives it one bit pair per cycle.
- Consumes that cell's sum and carry-out and feeds the carry back through a register.
- Gives the team a small-area multi-bit adder with a start/done handshake, for use by later datapath blocks.

Parameters:
- WIDTH, 8, operand and sum width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  request; sampled on rising clk edge; accepted only when busy=0.
- a  input  WIDTH  operand A; captured on the accept edge only.
- b  input  WIDTH  operand B; captured on the accept edge only.
- c_in  input  1  carry-in; captured on the accept edge only.
- busy  output  1  high while an addition is in progress.
- done  output  1  single-cycle pulse: sum and c_out have just updated.
- sum  output  WIDTH  registered result; holds its value until the next done.
- c_out  output  1  registered carry-out; holds its value until the next done.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, c_out=0.
  - Reset also clears the internal operand shift registers, carry register, partial-sum register and bit counter.
  - Reset mid-operation abandons the addition; no done pulse is produced.
  - After reset releases, the first start is accepted normally.
- Datapath:
  - One instance of full_adder.
  - x = a_sh[0], y = b_sh[0], c_in = carry_q.
  - Each RUN cycle: a_sh and b_sh shift right by one with 0 filled at the MSB.
  - Each RUN cycle: the full_adder s output shifts into the MSB of the partial-sum register p_sh, which shifts right.
  - Each RUN cycle: carry_q <= full_adder c_out.
- Bit counter: width clog2(WIDTH+1); counts 0..WIDTH-1 in RUN.
- FSM states: IDLE, RUN.
  - IDLE, start=1 at edge E: load a_sh=a, b_sh=b, carry_q=c_in; clear count; go to RUN; busy=1 after edge E.
  - IDLE, start=0: remain in IDLE.
  - RUN: performs one bit step per edge. On the edge where count==WIDTH-1:
    - sum <= {s, p_sh[WIDTH-1:1]} (final bit included);
    - c_out <= full_adder c_out;
    - done <= 1, busy <= 0, go to IDLE.
- Latency: accept at edge E; done=1 and the result is valid during the cycle after edge E+WIDTH.
- done is high for exactly one cycle, then cleared on the next edge.
- start while busy=1 is ignored, including in the final RUN cycle; operands are not recaptured.
- Back-to-back: start asserted in the done cycle is accepted, because busy=0 then.
  - sum and c_out keep the old result until the new done pulse.
- sum and c_out never change mid-computation. a, b and c_in may change freely after the accept edge.
- Arithmetic is unsigned: {c_out, sum} = a + b + c_in, exact modulo 2^(WIDTH+1).
- Fully synchronous except rst_n. No combinational path from any input to any output.

Test Plan:
1. WIDTH=8; reset, then start with a=0x00, b=0x00, c_in=0 -> done pulses 8 cycles after the accept edge; sum=0x00, c_out=0; busy high for exactly 8 cycles.
2. a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1. Then a=0x3C, b=0x42, c_in=0 -> sum=0x7E, c_out=0. Then a=0xA5, b=0x5A, c_in=1 -> sum=0x00, c_out=1.
3. Start a=0x12, b=0x34, c_in=0; pulse start with a=0xFF, b=0xFF at cycle 3 of RUN -> pulse ignored; result sum=0x46, c_out=0; exactly one done pulse.
4. Back-to-back: start a=0x80, b=0x80 -> done with sum=0x00, c_out=1. In that done cycle, start a=0x01, b=0x02, c_in=1 -> sum/c_out hold 0x00/1 for 8 cycles, then update to sum=0x04, c_out=0.
5. Reset mid-operation: start a=0xF0, b=0x0F; drop rst_n asynchronously at cycle 4 -> busy, done, sum and c_out go to 0 immediately; no done pulse follows. After release, start a=0x01, b=0x01 -> sum=0x02, c_out=0.
6. Randomized check of 200 vectors (WIDTH=8 and WIDTH=16) against a+b+c_in -> all {c_out, sum} match; done exactly WIDTH cycles after each accept.

Source files
------------

// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit unsigned adder built around one full_adder.
// An operand pair is accepted with a start/busy handshake. It is then added one bit
// pair per clock, LSB first, and the carry is fed back through a register.
// {c_out, sum} = a + b + c_in. The result is valid in the cycle where done pulses.
//
// Ports:
//   clk    - system clock, rising edge
//   rst_n  - asynchronous active-low reset
//   start  - request; accepted only while busy is low
//   a, b   - WIDTH-bit operands, captured on the accept edge
//   c_in   - carry-in, captured on the accept edge
//   busy   - high while an addition is in progress
//   done   - one-cycle pulse when sum/c_out have just updated
//   sum    - registered WIDTH-bit result, held until the next done
//   c_out  - registered carry-out, held until the next done

// full_adder: single-bit combinational full adder cell.
// Ports: x, y, c_in (inputs); s, c_out (outputs).
module full_adder (
  input  logic x,
  input  logic y,
  input  logic c_in,
  output logic s,
  output logic c_out
);
  assign s     = x ^ y ^ c_in;
  assign c_out = (x & y) | (c_in & (x ^ y));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           next_state;
  logic             accept;
  logic             last;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-2:0] p_sh;
  logic             carry_q;
  logic [CW-1:0]    count;

  logic             fa_s;
  logic             fa_cout;
  logic [WIDTH-1:0] p_next;

  full_adder u_fa (
    .x     (a_sh[0]),
    .y     (b_sh[0]),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_cout)
  );

  // p_sh only keeps the upper WIDTH-1 result bits gathered so far. The newest bit
  // enters at the MSB, so on the final step p_next is the complete sum.
  assign p_next = {fa_s, p_sh};

  assign busy = (state == RUN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          next_state = RUN;
        end
      end
      RUN: begin
        if (count == LAST_CNT) begin
          last       = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh    <= '0;
      b_sh    <= '0;
      p_sh    <= '0;
      carry_q <= 1'b0;
      count   <= '0;
      sum     <= '0;
      c_out   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        a_sh    <= a;
        b_sh    <= b;
        carry_q <= c_in;
        count   <= '0;
      end else if (state == RUN) begin
        a_sh    <= a_sh >> 1;
        b_sh    <= b_sh >> 1;
        p_sh    <= p_next[WIDTH-1:1];
        carry_q <= fa_cout;
        count   <= count + CW'(1);
        if (last) begin
          sum   <= p_next;
          c_out <= fa_cout;
          done  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: directed self-checking bench for serial_adder with WIDTH=8.
// It covers the reset state, latency, busy length and arithmetic on hand-computed vectors.
// It also checks that start is ignored while busy, that a request in the done cycle
// is accepted back-to-back, and that a mid-operation asynchronous reset abandons the addition.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int           n_checks;
  int           n_fail;
  logic [W-1:0] last_sum;
  logic         last_cout;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive a request from an off-edge point and return #1 after the accept edge.
  // The operand inputs are then scrambled to show they were captured.
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv);
    a     = av;
    b     = bv;
    c_in  = cv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = ~av;
    b     = bv ^ 8'h5A;
    c_in  = ~cv;
  endtask

  // Wait for done with a bounded budget. While waiting, check that busy stays high and
  // the old result holds. An optional stray start is pulsed at RUN cycle inject_at.
  // It returns #1 after the edge that raised done, which is inside the done cycle.
  task automatic waitDone(input string tag, input logic [W-1:0] es, input logic ec,
                          input int inject_at);
    int lat;
    lat = 0;
    while (!done && lat < W + 4) begin
      checkOutput({tag, " busy"}, 32'(busy), 32'd1);
      checkOutput({tag, " hold_sum"}, 32'(sum), 32'(last_sum));
      if (lat == inject_at) begin
        start = 1'b1;
        a     = 8'hFF;
        b     = 8'hFF;
        c_in  = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    start = 1'b0;
    checkOutput({tag, " latency"}, 32'(lat), 32'(W));
    checkOutput({tag, " done"}, 32'(done), 32'd1);
    checkOutput({tag, " busy_low"}, 32'(busy), 32'd0);
    checkOutput({tag, " sum"}, 32'(sum), 32'(es));
    checkOutput({tag, " c_out"}, 32'(c_out), 32'(ec));
    last_sum  = es;
    last_cout = ec;
  endtask

  // After done, confirm that it drops and no new operation was started.
  task automatic checkIdle(input string tag);
    @(posedge clk);
    #1;
    checkOutput({tag, " done_clr"}, 32'(done), 32'd0);
    checkOutput({tag, " idle"}, 32'(busy), 32'd0);
    checkOutput({tag, " keep_sum"}, 32'(sum), 32'(last_sum));
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    last_sum  = '0;
    last_cout = 1'b0;
    rst_n     = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset sum", 32'(sum), 32'd0);
    checkOutput("reset c_out", 32'(c_out), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] zero operands");
    applyStimulus(8'h00, 8'h00, 1'b0);
    waitDone("zero", 8'h00, 1'b0, -1);
    checkIdle("zero");

    $display("[TB] directed arithmetic");
    applyStimulus(8'hFF, 8'h01, 1'b0);
    waitDone("ff+01", 8'h00, 1'b1, -1);
    checkIdle("ff+01");
    applyStimulus(8'h3C, 8'h42, 1'b0);
    waitDone("3c+42", 8'h7E, 1'b0, -1);
    checkIdle("3c+42");
    applyStimulus(8'hA5, 8'h5A, 1'b1);
    waitDone("a5+5a+1", 8'h00, 1'b1, -1);
    checkIdle("a5+5a+1");
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    waitDone("ff+ff+1", 8'hFF, 1'b1, -1);
    checkIdle("ff+ff+1");
    applyStimulus(8'h7F, 8'h01, 1'b0);
    waitDone("7f+01", 8'h80, 1'b0, -1);
    checkIdle("7f+01");
    applyStimulus(8'h55, 8'hAA, 1'b0);
    waitDone("55+aa", 8'hFF, 1'b0, -1);
    checkIdle("55+aa");
    applyStimulus(8'h99, 8'h66, 1'b1);
    waitDone("99+66+1", 8'h00, 1'b1, -1);
    checkIdle("99+66+1");

    $display("[TB] start ignored while busy");
    applyStimulus(8'h12, 8'h34, 1'b0);
    waitDone("ign_mid", 8'h46, 1'b0, 3);
    checkIdle("ign_mid");
    applyStimulus(8'h21, 8'h10, 1'b1);
    waitDone("ign_last", 8'h32, 1'b0, W - 1);
    checkIdle("ign_last");

    $display("[TB] back-to-back");
    applyStimulus(8'h80, 8'h80, 1'b0);
    waitDone("b2b_first", 8'h00, 1'b1, -1);
    applyStimulus(8'h01, 8'h02, 1'b1);
    checkOutput("b2b done_clr", 32'(done), 32'd0);
    checkOutput("b2b hold_cout", 32'(c_out), 32'd1);
    waitDone("b2b_second", 8'h04, 1'b0, -1);
    checkIdle("b2b_second");

    $display("[TB] reset mid-operation");
    applyStimulus(8'hF0, 8'h0F, 1'b0);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid busy", 32'(busy), 32'd0);
    checkOutput("rst_mid done", 32'(done), 32'd0);
    checkOutput("rst_mid sum", 32'(sum), 32'd0);
    checkOutput("rst_mid c_out", 32'(c_out), 32'd0);
    last_sum  = '0;
    last_cout = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < W + 2; i++) begin
      @(posedge clk);
      #1;
      checkOutput("rst_mid no_done", 32'(done), 32'd0);
    end
    applyStimulus(8'h01, 8'h01, 1'b0);
    waitDone("after_rst", 8'h02, 1'b0, -1);
    checkIdle("after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
